// File: rtl/matrix_pkg.sv
// Shared types and sizing helpers for the matrix loader block.
package matrix_pkg;

  localparam int DEFAULT_WIDTH_BIT = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    FULL,
    ERROR
  } loader_state_t;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Index counters never shrink below one bit, even for 1x1 matrices.
  function automatic int ctrWidth(input int rows, input int cols);
    int w;
    w = $clog2(maxInt(rows, cols));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// Stream-in / matrix-out bundle between a producer, the loader and its consumer.
interface matrix_loader_if #(
  parameter int AROWS     = 3,
  parameter int ACOLUMNS  = 3,
  parameter int BROWS     = 3,
  parameter int BCOLUMNS  = 3,
  parameter int WIDTH_BIT = matrix_pkg::DEFAULT_WIDTH_BIT
);

  logic                        start;
  logic                        in_valid;
  logic signed [WIDTH_BIT-1:0] in_data;
  logic                        in_last;
  logic                        in_ready;
  logic signed [WIDTH_BIT-1:0] MatrixA [AROWS-1:0][ACOLUMNS-1:0];
  logic signed [WIDTH_BIT-1:0] MatrixB [BROWS-1:0][BCOLUMNS-1:0];
  logic                        mat_valid;
  logic                        mat_ack;
  logic                        busy;
  logic                        err;

  modport master (
    output start, in_valid, in_data, in_last, mat_ack,
    input  in_ready, MatrixA, MatrixB, mat_valid, busy, err
  );

  modport slave (
    input  start, in_valid, in_data, in_last, mat_ack,
    output in_ready, MatrixA, MatrixB, mat_valid, busy, err
  );

endinterface

// File: rtl/matrix_rc_counter.sv
// Row-major row/column index counter with run-time wrap limits and a last-element flag.
module matrix_rc_counter #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         nreset,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic [W-1:0] lastRow_i,
  input  logic [W-1:0] lastCol_i,
  output logic [W-1:0] row_o,
  output logic [W-1:0] col_o,
  output logic         last_o
);

  logic [W-1:0] row_q, row_d;
  logic [W-1:0] col_q, col_d;

  // Clear wins over enable so a matrix switch restarts at element 0.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (enable_i) begin
      if (col_q == lastCol_i) begin
        col_d = '0;
        row_d = (row_q == lastRow_i) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == lastRow_i) && (col_q == lastCol_i);

endmodule

// File: rtl/matrix_loader.sv
// Loads MatrixA then MatrixB from a single valid/ready element stream and holds them for a consumer.
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int AROWS     = 3,
  parameter int ACOLUMNS  = 3,
  parameter int BROWS     = 3,
  parameter int BCOLUMNS  = 3,
  parameter int WIDTH_BIT = DEFAULT_WIDTH_BIT
) (
  input logic            clock,
  input logic            nreset,
  matrix_loader_if.slave bus
);

  localparam int CW = ctrWidth(maxInt(AROWS, BROWS), maxInt(ACOLUMNS, BCOLUMNS));

  if (ACOLUMNS != BROWS) begin : gBadDims
    $error("matrix_loader: ACOLUMNS must equal BROWS");
  end

  loader_state_t state_q, state_d;

  logic          loading;
  logic          accept;
  logic          ctrClear;
  logic          ctrLast;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic [CW-1:0] lastRow;
  logic [CW-1:0] lastCol;

  logic signed [WIDTH_BIT-1:0] matA_q [AROWS-1:0][ACOLUMNS-1:0];
  logic signed [WIDTH_BIT-1:0] matB_q [BROWS-1:0][BCOLUMNS-1:0];

  assign loading = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign accept  = bus.in_valid && loading;
  assign lastRow = (state_q == LOAD_B) ? CW'(BROWS - 1)    : CW'(AROWS - 1);
  assign lastCol = (state_q == LOAD_B) ? CW'(BCOLUMNS - 1) : CW'(ACOLUMNS - 1);

  matrix_rc_counter #(
    .W(CW)
  ) u_rc_counter (
    .clock     (clock),
    .nreset    (nreset),
    .clear_i   (ctrClear),
    .enable_i  (accept),
    .lastRow_i (lastRow),
    .lastCol_i (lastCol),
    .row_o     (row),
    .col_o     (col),
    .last_o    (ctrLast)
  );

  // in_last is only legal on the final B element; anywhere else it is a framing error.
  always_comb begin
    state_d  = state_q;
    ctrClear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = LOAD_A;
          ctrClear = 1'b1;
        end
      end
      LOAD_A: begin
        if (accept) begin
          if (bus.in_last) begin
            state_d = ERROR;
          end else if (ctrLast) begin
            state_d  = LOAD_B;
            ctrClear = 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (accept) begin
          if (ctrLast && bus.in_last) begin
            state_d = FULL;
          end else if (ctrLast || bus.in_last) begin
            state_d = ERROR;
          end
        end
      end
      FULL: begin
        if (bus.mat_ack) begin
          state_d = IDLE;
        end
      end
      ERROR: begin
        if (bus.start) begin
          state_d  = LOAD_A;
          ctrClear = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The offending beat of a framing error is still stored.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int r = 0; r < AROWS; r++) begin
        for (int c = 0; c < ACOLUMNS; c++) begin
          matA_q[r][c] <= '0;
        end
      end
      for (int r = 0; r < BROWS; r++) begin
        for (int c = 0; c < BCOLUMNS; c++) begin
          matB_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      if (state_q == LOAD_A) begin
        matA_q[row][col] <= bus.in_data;
      end else begin
        matB_q[row][col] <= bus.in_data;
      end
    end
  end

  assign bus.in_ready  = loading;
  assign bus.busy      = loading;
  assign bus.mat_valid = (state_q == FULL);
  assign bus.err       = (state_q == ERROR);
  assign bus.MatrixA   = matA_q;
  assign bus.MatrixB   = matB_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for a 2x2 by 2x2, 8-bit matrix_loader: vector tables plus framing/reset/handshake sequences.
module tb_matrix_loader;

  localparam int N = 2;
  localparam int W = 8;

  typedef struct {
    logic                start;
    logic                valid;
    logic signed [W-1:0] data;
    logic                last;
    logic                ack;
    logic                expReady;
    logic                expBusy;
    logic                expMatValid;
    logic                expErr;
  } vec_t;

  logic clock;
  logic nreset;
  int   checks;
  int   errors;
  vec_t vecs[$];
  int   expA[4];
  int   expB[4];

  matrix_loader_if #(
    .AROWS(N), .ACOLUMNS(N), .BROWS(N), .BCOLUMNS(N), .WIDTH_BIT(W)
  ) bus ();

  matrix_loader #(
    .AROWS(N), .ACOLUMNS(N), .BROWS(N), .BCOLUMNS(N), .WIDTH_BIT(W)
  ) dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    bus.start    = v.start;
    bus.in_valid = v.valid;
    bus.in_data  = v.data;
    bus.in_last  = v.last;
    bus.mat_ack  = v.ack;
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic s, input logic v, input int d, input logic l, input logic a);
    vec_t t;
    t = '{start: s, valid: v, data: W'(d), last: l, ack: a,
          expReady: 1'b0, expBusy: 1'b0, expMatValid: 1'b0, expErr: 1'b0};
    applyStimulus(t);
  endtask

  task automatic addVec(input logic s, input logic v, input int d, input logic l, input logic a,
                        input logic er, input logic eb, input logic em, input logic ee);
    vecs.push_back('{start: s, valid: v, data: W'(d), last: l, ack: a,
                     expReady: er, expBusy: eb, expMatValid: em, expErr: ee});
  endtask

  task automatic checkStatus(input string tag, input int er, input int eb, input int em, input int ee);
    checkOutput({tag, ".in_ready"},  int'(bus.in_ready),  er);
    checkOutput({tag, ".busy"},      int'(bus.busy),      eb);
    checkOutput({tag, ".mat_valid"}, int'(bus.mat_valid), em);
    checkOutput({tag, ".err"},       int'(bus.err),       ee);
  endtask

  task automatic checkMatrices(input string tag);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        checkOutput($sformatf("%s.A[%0d][%0d]", tag, r, c), int'(bus.MatrixA[r][c]), expA[r*N+c]);
        checkOutput($sformatf("%s.B[%0d][%0d]", tag, r, c), int'(bus.MatrixB[r][c]), expB[r*N+c]);
      end
    end
  endtask

  task automatic runTable(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkStatus($sformatf("%s[%0d]", tag, i), int'(vecs[i].expReady), int'(vecs[i].expBusy),
                  int'(vecs[i].expMatValid), int'(vecs[i].expErr));
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    nreset       = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.mat_ack  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    expA = '{0, 0, 0, 0};
    expB = '{0, 0, 0, 0};
    checkStatus("reset", 0, 0, 0, 0);
    checkMatrices("reset");
    @(negedge clock);
    nreset = 1'b1;

    // Plain stream 1..8, then ack; a stray beat and ack while idle must do nothing.
    vecs.delete();
    addVec(1, 0, 0, 0, 0, 1, 1, 0, 0);
    for (int k = 1; k <= 7; k++) addVec(0, 1, k, 0, 0, 1, 1, 0, 0);
    addVec(0, 1, 8, 1, 0, 0, 0, 1, 0);
    addVec(0, 0, 0, 0, 1, 0, 0, 0, 0);
    addVec(0, 1, 55, 1, 1, 0, 0, 0, 0);
    runTable("stream");
    expA = '{1, 2, 3, 4};
    expB = '{5, 6, 7, 8};
    checkMatrices("stream");

    // Gapped stream: idle cycles carry junk data, in_last, ack and a mid-load start.
    vecs.delete();
    addVec(1, 0, 0, 0, 0, 1, 1, 0, 0);
    for (int k = 11; k <= 18; k++) begin
      addVec(k == 13, 0, 99, 1, 1, 1, 1, 0, 0);
      if (k == 18) addVec(0, 1, k, 1, 0, 0, 0, 1, 0);
      else         addVec(0, 1, k, 0, 0, 1, 1, 0, 0);
    end
    runTable("toggle");

    // FULL held for 10 cycles without ack; offered beats must not disturb the matrices.
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 77, 1, 0);
      checkOutput($sformatf("hold[%0d].mat_valid", i), int'(bus.mat_valid), 1);
    end
    step(0, 0, 0, 0, 1);
    checkStatus("ackdone", 0, 0, 0, 0);
    expA = '{11, 12, 13, 14};
    expB = '{15, 16, 17, 18};
    checkMatrices("toggle");

    // Early in_last on beat 5.
    step(1, 0, 0, 0, 0);
    for (int k = 21; k <= 24; k++) step(0, 1, k, 0, 0);
    step(0, 1, 25, 1, 0);
    checkStatus("earlyLast", 0, 0, 0, 1);
    checkOutput("earlyLast.B00", int'(bus.MatrixB[0][0]), 25);
    checkOutput("earlyLast.A11", int'(bus.MatrixA[1][1]), 24);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 66, 1, 1);
      checkStatus($sformatf("errHold[%0d]", i), 0, 0, 0, 1);
    end
    checkOutput("errHold.B01", int'(bus.MatrixB[0][1]), 16);
    step(1, 0, 0, 0, 0);
    checkStatus("restart", 1, 1, 0, 0);

    // Missing in_last on the final B beat.
    for (int k = 31; k <= 38; k++) step(0, 1, k, 0, 0);
    checkStatus("noLast", 0, 0, 0, 1);
    checkOutput("noLast.B11", int'(bus.MatrixB[1][1]), 38);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      checkStatus($sformatf("noLastHold[%0d]", i), 0, 0, 0, 1);
    end

    // Reset in the middle of loading A, then a full reload.
    step(1, 0, 0, 0, 0);
    for (int k = 41; k <= 43; k++) step(0, 1, k, 0, 0);
    @(negedge clock);
    nreset       = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.mat_ack  = 1'b0;
    #1;
    expA = '{0, 0, 0, 0};
    expB = '{0, 0, 0, 0};
    checkStatus("midReset", 0, 0, 0, 0);
    checkMatrices("midReset");
    @(negedge clock);
    nreset = 1'b1;
    step(1, 0, 0, 0, 0);
    checkStatus("reloadStart", 1, 1, 0, 0);
    for (int k = 51; k <= 57; k++) step(0, 1, k, 0, 0);
    step(0, 1, 58, 1, 0);
    checkStatus("reload", 0, 0, 1, 0);
    expA = '{51, 52, 53, 54};
    expB = '{55, 56, 57, 58};
    checkMatrices("reload");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
